// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle controller for a restoring shift-subtract divider (DIV/DIVU).
// Latches one request, runs one quotient bit per clock, applies the sign fix-up,
// then pulses done/hilo_we with HI=remainder, LO=quotient. Holds the pipeline via stall_req.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, is_signed    request pulse (IDLE only) and signed-divide select
//   dividend, divisor   W-bit operands, sampled with start
//   flush               aborts any in-flight divide
//   busy, stall_req     high whenever the sequencer is not idle
//   done, hilo_we       one-cycle result strobe
//   quotient, remainder result registers, held until the next done
//   div_by_zero         set by a zero-divisor done, cleared by the next normal done
module div_sequencer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         flush,
    output logic         busy,
    output logic         stall_req,
    output logic         done,
    output logic         hilo_we,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_d;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sgn_q;
    logic [W-1:0]  b_mag_q;
    logic          neg_q;
    logic          neg_r;
    logic [W:0]    rem_r;
    logic [W-1:0]  quo_r;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          sa;
    logic          sb;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W+1:0]  t_val;
    logic          t_ge;
    logic [W-1:0]  quo_fix;
    logic [W-1:0]  rem_fix;

    // Datapath combinational terms: magnitudes, trial subtract, sign fix-up
    always_comb begin
        accept  = start && !flush;
        sa      = sgn_q & a_q[W-1];
        sb      = sgn_q & b_q[W-1];
        a_mag   = sa ? W'(-a_q) : a_q;
        b_mag   = sb ? W'(-b_q) : b_q;
        // T = ({R,Q} << 1).R - {0,|b|}, one extra bit so its MSB is the sign of T
        t_val   = {rem_r, quo_r[W-1]} - {2'b00, b_mag_q};
        t_ge    = ~t_val[W+1];
        quo_fix = neg_q ? W'(-quo_r) : quo_r;
        rem_fix = neg_r ? W'(-rem_r[W-1:0]) : rem_r[W-1:0];
        // Zero divisor: all-ones quotient, raw dividend as remainder
        if (b_q == '0) begin
            quo_fix = '1;
            rem_fix = a_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept) state_d = S_PREP;
            // Zero divisor skips RUN but still passes through FIX, giving a fixed two-edge latency
            S_PREP: state_d = (b_q == '0) ? S_FIX : S_RUN;
            S_RUN:  if (cnt == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && state != S_IDLE) state_d = S_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Operand latch and shift-subtract iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_r   <= '0;
            quo_r   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q   <= dividend;
                        b_q   <= divisor;
                        sgn_q <= is_signed;
                    end
                end
                S_PREP: begin
                    rem_r   <= '0;
                    quo_r   <= a_mag;
                    b_mag_q <= b_mag;
                    neg_q   <= sa ^ sb;
                    neg_r   <= sa;
                    cnt     <= CW'(W);
                end
                S_RUN: begin
                    rem_r <= t_ge ? t_val[W:0] : {rem_r[W-1:0], quo_r[W-1]};
                    quo_r <= {quo_r[W-2:0], t_ge};
                    cnt   <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; results change only on the FIX -> DONE transition
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            stall_req   <= 1'b0;
            done        <= 1'b0;
            hilo_we     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy      <= (state_d != S_IDLE);
            stall_req <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            hilo_we   <= (state_d == S_DONE);
            if (state == S_FIX && state_d == S_DONE) begin
                quotient    <= quo_fix;
                remainder   <= rem_fix;
                div_by_zero <= (b_q == '0);
            end
        end
    end

endmodule
